// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Covers framing states, prefix-decode states and the queued key event.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int N_FILT = 6;
    localparam logic [7:0] PS2_FILT [N_FILT] = '{
        8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF
    };

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PAR,
        F_STOP
    } frame_state_e;

    typedef enum logic [1:0] {
        D_BASE,
        D_EXT,
        D_BRK,
        D_EXT_BRK
    } dec_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_ev_t;

    function automatic logic is_filtered(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_FILT; i++) begin
            if (code == PS2_FILT[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser and 11-bit frame receiver.
// Emits one byte_vld pulse per good frame, one frame_err pulse per dropped frame.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       kb_clk_i,
    input  logic       kb_data_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]   clk_sync_q;
    logic [1:0]   data_sync_q;
    logic         clk_prev_q;
    logic         neg_pulse;
    logic         bit_in;

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic         byte_vld_q, byte_vld_d;
    logic         frame_err_q, frame_err_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], kb_clk_i};
            data_sync_q <= {data_sync_q[0], kb_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign neg_pulse = clk_prev_q & ~clk_sync_q[1];
    assign bit_in    = data_sync_q[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= F_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        tmo_d       = (neg_pulse || state_q == F_IDLE) ? '0 : tmo_q + TW'(1);

        if (neg_pulse) begin
            unique case (state_q)
                F_IDLE: begin
                    if (!bit_in) begin
                        state_d   = F_DATA;
                        bit_cnt_d = '0;
                    end
                end
                F_DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = F_PAR;
                end
                F_PAR: begin
                    par_d   = bit_in;
                    state_d = F_STOP;
                end
                F_STOP: begin
                    state_d = F_IDLE;
                    // odd parity over data+parity and a high stop bit
                    if (bit_in && ^{shift_q, par_q}) byte_vld_d = 1'b1;
                    else frame_err_d = 1'b1;
                end
                default: state_d = F_IDLE;
            endcase
        end else if (state_q != F_IDLE && tmo_q == TMO_LAST) begin
            state_d     = F_IDLE;
            frame_err_d = 1'b1;
        end
    end

    assign byte_o      = shift_q;
    assign byte_vld_o  = byte_vld_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 keyboard front end: frame receive, E0/F0 prefix decode, event FIFO.
// Also tracks the last make code, dropped-frame count and FIFO overflow.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic [7:0] display_o,
    output logic [7:0] err_cnt,
    output logic       overflow,
    input  logic       err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i       (sys_clk),
        .reset_i     (reset),
        .kb_clk_i    (kb_clk),
        .kb_data_i   (kb_data),
        .byte_o      (rx_byte),
        .byte_vld_o  (rx_vld),
        .frame_err_o (rx_err)
    );

    dec_state_e dec_q, dec_d;
    logic       push;
    ps2_ev_t    push_ev;

    ps2_ev_t    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] err_q, err_d;
    logic       ovf_q, ovf_d;
    logic [7:0] disp_q, disp_d;

    logic       full;
    logic       pop;
    logic       wr_ok;

    always_comb begin
        dec_d   = dec_q;
        push    = 1'b0;
        push_ev = '0;
        if (rx_vld) begin
            dec_d = D_BASE;
            if (rx_byte == PS2_EXT) begin
                dec_d = D_EXT;
            end else if (rx_byte == PS2_BRK) begin
                // a second F0 is a protocol error and falls back to D_BASE
                if (dec_q == D_BASE) dec_d = D_BRK;
                else if (dec_q == D_EXT) dec_d = D_EXT_BRK;
            end else if (!is_filtered(rx_byte)) begin
                push         = 1'b1;
                push_ev.ext  = (dec_q == D_EXT) || (dec_q == D_EXT_BRK);
                push_ev.brk  = (dec_q == D_BRK) || (dec_q == D_EXT_BRK);
                push_ev.code = rx_byte;
            end
        end
    end

    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign ev_valid = (cnt_q != '0);
    assign pop      = ev_valid & ev_ready;
    assign wr_ok    = push & (~full | pop);

    always_comb begin
        rd_d   = pop   ? rd_q + AW'(1) : rd_q;
        wr_d   = wr_ok ? wr_q + AW'(1) : wr_q;
        cnt_d  = cnt_q;
        if (wr_ok && !pop) cnt_d = cnt_q + CW'(1);
        else if (!wr_ok && pop) cnt_d = cnt_q - CW'(1);

        err_d  = err_q;
        ovf_d  = ovf_q;
        if (err_clr) begin
            err_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (rx_err && err_q != 8'hFF) err_d = err_q + 8'd1;
            if (push && !wr_ok) ovf_d = 1'b1;
        end

        disp_d = (push && !push_ev.brk) ? push_ev.code : disp_q;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            dec_q  <= D_BASE;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
            ovf_q  <= 1'b0;
            disp_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            dec_q  <= dec_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            ovf_q  <= ovf_d;
            disp_q <= disp_d;
            if (wr_ok) mem_q[wr_q] <= push_ev;
        end
    end

    assign ev_code   = mem_q[rd_q].code;
    assign ev_ext    = mem_q[rd_q].ext;
    assign ev_brk    = mem_q[rd_q].brk;
    assign display_o = disp_q;
    assign err_cnt   = err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: drives PS/2 frames, compares against a key-event model.
// Model tracks prefix flags, an event queue, last make code and error counters.
module tb_ps2_scan_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 5000;
    localparam int HP    = 8;

    logic       sys_clk  = 1'b0;
    logic       reset    = 1'b1;
    logic       kb_clk   = 1'b1;
    logic       kb_data  = 1'b1;
    logic       ev_ready = 1'b0;
    logic       err_clr  = 1'b0;
    logic       ev_valid, ev_ext, ev_brk, overflow;
    logic [7:0] ev_code, display_o, err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] mq [$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_disp = 8'h00;
    int         m_err = 0;

    ps2_scan_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .kb_clk    (kb_clk),
        .kb_data   (kb_data),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .display_o (display_o),
        .err_cnt   (err_cnt),
        .overflow  (overflow),
        .err_clr   (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                             input logic bad_par,
                                             input logic bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good) begin
            if (m_err < 255) m_err++;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
            m_brk = 1'b0;
        end else if (b == 8'hF0) begin
            if (m_brk) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else begin
                m_brk = 1'b1;
            end
        end else if (b inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF}) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            if (!m_brk) m_disp = b;
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic kb_bit(input logic b);
        @(negedge sys_clk);
        kb_data = b;
        repeat (HP) @(negedge sys_clk);
        kb_clk = 1'b0;
        repeat (HP) @(negedge sys_clk);
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bp, input logic bs);
        logic [10:0] f;
        f = mk_frame(b, bp, bs);
        for (int i = 0; i < 11; i++) kb_bit(f[i]);
        repeat (6) @(negedge sys_clk);
        model_frame(b, !(bp || bs));
    endtask

    task automatic drain(input string nm);
        logic [9:0] exp;
        int guard;
        guard = 0;
        while (ev_valid === 1'b1 && guard < DEPTH + 2) begin
            guard++;
            n_cmp++;
            if (mq.size() == 0) begin
                n_bad++;
                $display("FAIL %s unexpected event got=%b_%b_%h", nm, ev_ext, ev_brk, ev_code);
            end else begin
                exp = mq.pop_front();
                if ({ev_ext, ev_brk, ev_code} !== exp) begin
                    n_bad++;
                    $display("FAIL %s event got=%b_%b_%h want=%b_%b_%h", nm,
                             ev_ext, ev_brk, ev_code, exp[9], exp[8], exp[7:0]);
                end
            end
            ev_ready = 1'b1;
            @(negedge sys_clk);
            ev_ready = 1'b0;
        end
        n_cmp++;
        if (ev_valid !== 1'b0 || mq.size() != 0) begin
            n_bad++;
            $display("FAIL %s drained ev_valid=%b model_left=%0d want 0/0", nm, ev_valid, mq.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if ({ev_valid, ev_code, ev_ext, ev_brk, display_o, err_cnt, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_held outputs v=%b c=%h d=%h e=%h o=%b want all 0",
                     ev_valid, ev_code, display_o, err_cnt, overflow);
        end
        reset = 1'b0;
        repeat (5) @(negedge sys_clk);
        n_cmp++;
        if ({ev_valid, display_o, err_cnt, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_after outputs v=%b d=%h e=%h o=%b want all 0",
                     ev_valid, display_o, err_cnt, overflow);
        end
    endtask

    task automatic test_make_latency;
        logic [10:0] f;
        int n;
        f = mk_frame(8'h1C, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) kb_bit(f[i]);
        @(negedge sys_clk);
        kb_data = 1'b1;
        repeat (HP) @(negedge sys_clk);
        kb_clk = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (ev_valid === 1'b1) break;
        end
        n_cmp++;
        if (n != 4) begin
            n_bad++;
            $display("FAIL make_latency edges=%0d want 4", n);
        end
        @(negedge sys_clk);
        repeat (HP) @(negedge sys_clk);
        kb_clk = 1'b1;
        repeat (4) @(negedge sys_clk);
        model_frame(8'h1C, 1'b1);
        n_cmp++;
        if (display_o !== m_disp) begin
            n_bad++;
            $display("FAIL make_display got=%h want=%h", display_o, m_disp);
        end
        drain("make_1c");
    endtask

    task automatic test_prefixes;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_cmp++;
        if (display_o !== m_disp) begin
            n_bad++;
            $display("FAIL break_display got=%h want=%h", display_o, m_disp);
        end
        drain("break_1c");
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        drain("ext_break_75");
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        drain("ext_make_75");
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'h2C, 1'b0, 1'b0);
        drain("double_f0_filter");
        n_cmp++;
        if (display_o !== m_disp) begin
            n_bad++;
            $display("FAIL prefix_display got=%h want=%h", display_o, m_disp);
        end
    endtask

    task automatic test_errors;
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        n_cmp++;
        if (err_cnt !== 8'(m_err)) begin
            n_bad++;
            $display("FAIL err_count got=%0d want=%0d", err_cnt, m_err);
        end
        drain("err_no_events");
        @(negedge sys_clk);
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        m_err = 0;
        m_ovf = 1'b0;
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL err_clr got=%0d want=0", err_cnt);
        end
    endtask

    task automatic test_timeout;
        logic [10:0] f;
        f = mk_frame(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) kb_bit(f[i]);
        repeat (TMO + 100) @(negedge sys_clk);
        m_err++;
        n_cmp++;
        if (err_cnt !== 8'(m_err)) begin
            n_bad++;
            $display("FAIL timeout_err got=%0d want=%0d", err_cnt, m_err);
        end
        send_frame(8'h32, 1'b0, 1'b0);
        n_cmp++;
        if (display_o !== m_disp) begin
            n_bad++;
            $display("FAIL timeout_next_display got=%h want=%h", display_o, m_disp);
        end
        drain("timeout_next");
    endtask

    task automatic test_overflow;
        logic [10:0] f;
        for (int i = 0; i < 5; i++) send_frame(8'h15 + 8'(i), 1'b0, 1'b0);
        n_cmp++;
        if ({ev_valid, overflow, display_o} !== {1'b1, m_ovf, m_disp}) begin
            n_bad++;
            $display("FAIL ovf_state v=%b o=%b d=%h want v=1 o=%b d=%h",
                     ev_valid, overflow, display_o, m_ovf, m_disp);
        end
        @(negedge sys_clk);
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
        m_ovf = 1'b0;
        m_err = 0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear got=%b want=0", overflow);
        end
        f = mk_frame(8'h1A, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) kb_bit(f[i]);
        @(negedge sys_clk);
        kb_data = 1'b1;
        repeat (HP) @(negedge sys_clk);
        kb_clk = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if ({ev_ext, ev_brk, ev_code} !== mq[0]) begin
            n_bad++;
            $display("FAIL full_head got=%h want=%h", ev_code, mq[0][7:0]);
        end
        ev_ready = 1'b1;
        @(negedge sys_clk);
        ev_ready = 1'b0;
        void'(mq.pop_front());
        model_frame(8'h1A, 1'b1);
        repeat (HP) @(negedge sys_clk);
        kb_clk = 1'b1;
        repeat (4) @(negedge sys_clk);
        n_cmp++;
        if (overflow !== m_ovf) begin
            n_bad++;
            $display("FAIL push_pop_full overflow got=%b want=%b", overflow, m_ovf);
        end
        drain("push_pop_full");
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] f;
        send_frame(8'h2B, 1'b0, 1'b0);
        send_frame(8'h2B, 1'b1, 1'b0);
        f = mk_frame(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) kb_bit(f[i]);
        @(negedge sys_clk);
        reset = 1'b1;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        mq.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        m_disp = 8'h00;
        m_err = 0;
        n_cmp++;
        if ({ev_valid, ev_code, display_o, err_cnt, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid outputs v=%b c=%h d=%h e=%h o=%b want all 0",
                     ev_valid, ev_code, display_o, err_cnt, overflow);
        end
        send_frame(8'h4D, 1'b0, 1'b0);
        n_cmp++;
        if ({display_o, err_cnt} !== {m_disp, 8'(m_err)}) begin
            n_bad++;
            $display("FAIL reset_mid_next d=%h e=%0d want d=%h e=%0d",
                     display_o, err_cnt, m_disp, m_err);
        end
        drain("reset_mid_next");
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic bp, bs;
        int r;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
                default: b = 8'($urandom);
            endcase
            bp = 1'b0;
            bs = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) bp = 1'b1;
                else bs = 1'b1;
            end
            send_frame(b, bp, bs);
            n_cmp++;
            if ({display_o, err_cnt, overflow} !== {m_disp, 8'(m_err), m_ovf}) begin
                n_bad++;
                $display("FAIL rand_%0d byte=%h d=%h e=%0d o=%b want d=%h e=%0d o=%b",
                         k, b, display_o, err_cnt, overflow, m_disp, m_err, m_ovf);
            end
            if ($urandom_range(0, 3) != 0) drain("rand_drain");
        end
        drain("rand_final");
    endtask

    initial begin
        test_reset;
        test_make_latency;
        test_prefixes;
        test_errors;
        test_timeout;
        test_overflow;
        test_reset_mid_frame;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
